// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the shared tick-countdown timer and its arbiter.
package timer_pkg;

    // Controller state encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Default geometry: four requesters, 16-bit durations.
    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select. The requester just above the
// pointer has top priority, wrapping cyclically; the pointer itself is lowest.
module rr_arbiter
    import timer_pkg::*;
#(
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic            valid
);

    // Wide enough to hold ptr + NREQ before folding back into range.
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk the requesters from ptr+1 upward (mod NREQ); the first asserted one wins.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
        sel   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: one tick-countdown timer shared round-robin among NREQ
// requesters. A granted requester's duration is loaded, counted down on each
// tick, and a one-cycle done pulse is returned to that requester at zero.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dur,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      remaining
);

    localparam int PW = $clog2(NREQ);

    logic [1:0]      state;
    logic [PW-1:0]   ptr;        // last requester served or cancelled
    logic [PW-1:0]   sel;        // requester currently owning the timer

    logic [NREQ-1:0] arb_sel;
    logic            arb_valid;
    logic [PW-1:0]   arb_idx;
    logic [W-1:0]    arb_dur;
    logic [NREQ-1:0] sel_onehot;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Turn the arbiter's one-hot pick into an index and fetch that requester's duration.
    always_comb begin
        arb_idx = '0;
        arb_dur = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_sel[i]) begin
                arb_idx = PW'(i);
                arb_dur = dur[i*W +: W];
            end
        end
    end

    // One-hot form of the stored owner, used for the completion pulse.
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    // Controller: load on grant, count ticks, pulse done at zero; cancel drops straight to idle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
        if (!rst) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ - 1);
            sel       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick arriving in the load cycle is intentionally ignored.
                    if (arb_valid) begin
                        remaining <= arb_dur;
                        gnt       <= arb_sel;
                        busy      <= 1'b1;
                        sel       <= arb_idx;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!req[sel]) begin
                        // Cancel beats expiry: no done pulse for a dropped request.
                        gnt       <= '0;
                        busy      <= 1'b0;
                        remaining <= '0;
                        ptr       <= sel;
                        state     <= IDLE;
                    end else if (remaining == '0) begin
                        gnt   <= '0;
                        done  <= sel_onehot;
                        state <= DONE;
                    end else if (tick) begin
                        remaining <= remaining - W'(1);
                    end
                end
                DONE: begin
                    // Moving the pointer to the finisher sends it to the back of the queue.
                    ptr   <= sel;
                    busy  <= 1'b0;
                    done  <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt       <= '0;
                    busy      <= 1'b0;
                    done      <= '0;
                    remaining <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
